non_restoring_div_seq: RTL

// Multi-cycle sequencer for unsigned non-restoring division: one add/subtract step per clock

---
 rtl/non_restoring_div_seq.sv | 137 +++++++++++++
 1 files changed

// File: rtl/non_restoring_div_seq.sv
// rtl/non_restoring_div_seq.sv - sequential unsigned non-restoring divider, one add/sub step per clock
// Optional NRD_DIVZERO_EN: adds div0 output and a single-cycle zero-divisor shortcut.
module non_restoring_div_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH:0]   R
`ifdef NRD_DIVZERO_EN
    ,
    output logic             div0
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] qr_q, qr_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   r_q, r_d;
`ifdef NRD_DIVZERO_EN
    logic             div0_q, div0_d;
`endif

    // Datapath helpers: shifted partial remainder, one iteration step, final correction.
    logic [WIDTH:0] a_sh;
    logic [WIDTH:0] a_step;
    logic [WIDTH:0] a_fix;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            qr_q    <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
`ifdef NRD_DIVZERO_EN
            div0_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            qr_q    <= qr_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
`ifdef NRD_DIVZERO_EN
            div0_q  <= div0_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        qr_d    = qr_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
`ifdef NRD_DIVZERO_EN
        div0_d  = 1'b0;
`endif

        // Sign of the remainder before the shift selects subtract vs add.
        a_sh   = {a_q[WIDTH-1:0], qr_q[WIDTH-1]};
        a_step = a_q[WIDTH] ? (a_sh + {1'b0, m_q}) : (a_sh - {1'b0, m_q});
        a_fix  = a_q[WIDTH] ? (a_q + {1'b0, m_q}) : a_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = '0;
                    qr_d    = X;
                    m_d     = Y;
                    cnt_d   = CW'(WIDTH);
                    state_d = S_RUN;
`ifdef NRD_DIVZERO_EN
                    if (Y == '0) begin
                        state_d = S_DONE;
                        q_d     = '1;
                        r_d     = {1'b0, X};
                        div0_d  = 1'b1;
                    end
`endif
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d   = a_step;
                qr_d  = {qr_q[WIDTH-2:0], ~a_step[WIDTH]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                a_d     = a_fix;
                q_d     = qr_q;
                r_d     = a_fix;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q == S_RUN) || (state_q == S_FIX);
    assign done = (state_q == S_DONE);
    assign Q    = q_q;
    assign R    = r_q;
`ifdef NRD_DIVZERO_EN
    assign div0 = div0_q;
`endif

endmodule
